// File: rtl/tcb_lib_memory.sv
// TCB subordinate RAM: byte-enabled storage answering each transfer after a
// fixed delay, with optional per-request backpressure and out-of-range errors.
module tcb_lib_memory #(
    parameter int ABW  = 32,
    parameter int DBW  = 32,
    parameter int SLW  = 8,
    parameter int DLY  = 1,
    parameter int SIZ  = 1024,
    parameter int WAIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tcb_vld,
    output logic               tcb_rdy,
    input  logic               tcb_wen,
    input  logic [ABW-1:0]     tcb_adr,
    input  logic [DBW/SLW-1:0] tcb_ben,
    input  logic [DBW-1:0]     tcb_wdt,
    output logic [DBW-1:0]     tcb_rdt,
    output logic               tcb_err,
    output logic               tcb_rsp
);
    localparam int BEW = DBW / SLW;
    localparam int MAW = $clog2(SIZ);
    localparam int LBW = $clog2(BEW);
    localparam int WDS = SIZ / BEW;
    localparam logic [3:0]   WAIT_CNT = 4'(WAIT);
    localparam logic [ABW:0] SIZ_EXT  = (ABW+1)'(SIZ);

    logic [3:0]         cnt;
    logic               trn;
    logic               oor;
    logic               wr_en;
    logic [MAW-LBW-1:0] idx;
    logic [DBW-1:0]     mem [WDS];

    logic [DLY-1:0]          stg_vld;
    logic [DLY-1:0]          stg_err;
    logic [DLY-1:0][DBW-1:0] stg_rdt;

    assign tcb_rdy = (cnt == WAIT_CNT);
    assign trn     = tcb_vld & tcb_rdy;
    assign oor     = ({1'b0, tcb_adr} >= SIZ_EXT);
    assign idx     = tcb_adr[MAW-1:LBW];
    // A request presented while reset is held must not reach the storage.
    assign wr_en   = trn & tcb_wen & ~oor & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (trn) begin
            cnt <= '0;
        end else if (tcb_vld) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BEW; b++) begin
                if (tcb_ben[b]) begin
                    mem[idx][b*SLW +: SLW] <= tcb_wdt[b*SLW +: SLW];
                end
            end
        end
    end

    // Stage 0 samples the word before the same-edge write lands (read-before-write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld <= '0;
            stg_err <= '0;
            stg_rdt <= '0;
        end else begin
            stg_vld[0] <= trn;
            stg_err[0] <= trn & oor;
            stg_rdt[0] <= (trn && !oor) ? mem[idx] : '0;
            for (int i = 1; i < DLY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
                stg_err[i] <= stg_err[i-1];
                stg_rdt[i] <= stg_rdt[i-1];
            end
        end
    end

    assign tcb_rsp = stg_vld[DLY-1];
    assign tcb_err = stg_vld[DLY-1] & stg_err[DLY-1];
    assign tcb_rdt = stg_vld[DLY-1] ? stg_rdt[DLY-1] : '0;

endmodule

// File: tb/tb_tcb_lib_memory.sv
// Bench for tcb_lib_memory: three instances (DLY=1, DLY=2, DLY=3/WAIT=2)
// checked by a response scoreboard plus cycle-exact hand sequences.
module tb_tcb_lib_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic        vld_1, vld_2, vld_3;
    logic        rdy_1, rdy_2, rdy_3;
    logic [31:0] rdt_1, rdt_2, rdt_3;
    logic        err_1, err_2, err_3;
    logic        rsp_1, rsp_2, rsp_3;

    always #5 clk = ~clk;

    tcb_lib_memory #(.DLY(1), .WAIT(0)) u_d1 (
        .clk(clk), .rst(rst), .tcb_vld(vld_1), .tcb_rdy(rdy_1), .tcb_wen(wen),
        .tcb_adr(adr), .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_1),
        .tcb_err(err_1), .tcb_rsp(rsp_1)
    );

    tcb_lib_memory #(.DLY(2), .WAIT(0)) u_d2 (
        .clk(clk), .rst(rst), .tcb_vld(vld_2), .tcb_rdy(rdy_2), .tcb_wen(wen),
        .tcb_adr(adr), .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_2),
        .tcb_err(err_2), .tcb_rsp(rsp_2)
    );

    tcb_lib_memory #(.DLY(3), .WAIT(2)) u_d3 (
        .clk(clk), .rst(rst), .tcb_vld(vld_3), .tcb_rdy(rdy_3), .tcb_wen(wen),
        .tcb_adr(adr), .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt_3),
        .tcb_err(err_3), .tcb_rsp(rsp_3)
    );

    typedef struct {
        logic [31:0] rdt;
        logic        err;
        logic        chk;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
        logic [31:0] rdt;
        logic        err;
        logic        chk;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    vec_t vecs[15];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic reportStray(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: response seen with empty scoreboard", name);
    endtask

    task automatic compareRsp(input string tag, input exp_t e, input logic [31:0] rdt, input logic err);
        checkOutput({tag, "_err"}, 32'(err), 32'(e.err));
        if (e.chk) checkOutput({tag, "_rdt"}, rdt, e.rdt);
    endtask

    // Expected responses are queued at drive time and retired on each rsp strobe.
    always @(negedge clk) begin
        if (rsp_1 === 1'b1) begin
            if (q1.size() == 0) reportStray("d1_stray_rsp");
            else compareRsp("d1", q1.pop_front(), rdt_1, err_1);
        end
        if (rsp_2 === 1'b1) begin
            if (q2.size() == 0) reportStray("d2_stray_rsp");
            else compareRsp("d2", q2.pop_front(), rdt_2, err_2);
        end
        if (rsp_3 === 1'b1) begin
            if (q3.size() == 0) reportStray("d3_stray_rsp");
            else compareRsp("d3", q3.pop_front(), rdt_3, err_3);
        end
    end

    task automatic applyStimulus(input int inst, input logic w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] d,
                                 input logic [31:0] er, input logic ee, input logic ec);
        exp_t e;
        e.rdt = er;
        e.err = ee;
        e.chk = ec;
        wen   = w;
        adr   = a;
        ben   = b;
        wdt   = d;
        vld_1 = (inst == 1);
        vld_2 = (inst == 2);
        vld_3 = (inst == 3);
        case (inst)
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic idle();
        vld_1 = 1'b0;
        vld_2 = 1'b0;
        vld_3 = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rsp_pat[7];
        int rdy_pat[3];

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'h1122_3344, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'h2, 32'h0000_AA00, 32'h1122_3344, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0012, 4'hF, 32'h0000_0000, 32'h1122_AA44, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0400, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0400, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_03FC, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 4'h9, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_03FF, 4'hF, 32'h0000_0000, 32'hAA00_00DD, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'h1000_0010, 4'hF, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'h1122_AA44, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'h0000_03FC, 4'h0, 32'h0000_0000, 32'hAA00_00DD, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};

        rsp_pat = '{0, 0, 1, 1, 1, 1, 0};
        rdy_pat = '{0, 0, 1};

        rst = 1'b1;
        wen = 1'b0;
        adr = '0;
        ben = '0;
        wdt = '0;
        idle();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rdy_w0", 32'(rdy_1), 32'd1);
        checkOutput("reset_rsp", 32'(rsp_1), 32'd0);
        checkOutput("reset_rdt", rdt_1, 32'd0);
        checkOutput("reset_err", 32'(err_1), 32'd0);
        checkOutput("reset_rdy_w2", 32'(rdy_3), 32'd0);
        checkOutput("reset_rsp_d3", 32'(rsp_3), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // DLY=1 vectors back to back, one transfer per cycle.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, vecs[i].wen, vecs[i].adr, vecs[i].ben, vecs[i].wdt,
                          vecs[i].rdt, vecs[i].err, vecs[i].chk);
            step(1);
        end
        idle();
        step(3);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, 1'b1, 32'(i * 4), 4'hF, 32'(32'hA0 + i), 32'h0, 1'b0, 1'b0);
            step(1);
        end
        idle();
        step(3);

        // DLY=2 streaming reads: rsp must be a solid 4-cycle window two edges later.
        for (int i = 0; i < 7; i++) begin
            if (i < 4) applyStimulus(2, 1'b0, 32'(i * 4), 4'hF, 32'h0, 32'(32'hA0 + i), 1'b0, 1'b1);
            else idle();
            @(negedge clk);
            checkOutput($sformatf("d2_rsp_window_%0d", i), 32'(rsp_2), 32'(rsp_pat[i]));
            @(posedge clk);
            #1;
        end
        idle();
        step(3);

        applyStimulus(3, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("w2_rdy_%0d", i), 32'(rdy_3), 32'(rdy_pat[i]));
            @(posedge clk);
        end
        #1 idle();
        @(negedge clk);
        checkOutput("w2_rdy_after_trn", 32'(rdy_3), 32'd0);
        checkOutput("d3_rsp_e2", 32'(rsp_3), 32'd0);
        @(negedge clk);
        checkOutput("d3_rsp_e3", 32'(rsp_3), 32'd0);
        @(negedge clk);
        checkOutput("d3_rsp_e4", 32'(rsp_3), 32'd1);
        step(3);

        // vld drops for one cycle mid-wait: the counter must hold, not advance.
        applyStimulus(3, 1'b0, 32'h20, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
        @(posedge clk);
        #1 vld_3 = 1'b0;
        @(negedge clk);
        checkOutput("w2_drop_rdy_e0", 32'(rdy_3), 32'd0);
        @(posedge clk);
        #1 vld_3 = 1'b1;
        @(negedge clk);
        checkOutput("w2_drop_hold_e1", 32'(rdy_3), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("w2_drop_rdy_e2", 32'(rdy_3), 32'd1);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        checkOutput("w2_drop_rsp_e3", 32'(rsp_3), 32'd0);
        @(negedge clk);
        checkOutput("w2_drop_rsp_e4", 32'(rsp_3), 32'd0);
        @(negedge clk);
        checkOutput("w2_drop_rsp_e5", 32'(rsp_3), 32'd1);
        step(2);

        // Reset one cycle after a DLY=3 read transfer discards its response.
        wen   = 1'b0;
        adr   = 32'h20;
        ben   = 4'hF;
        vld_3 = 1'b1;
        repeat (3) @(posedge clk);
        #1 idle();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_drop_rsp_%0d", i), 32'(rsp_3), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_post_rsp_%0d", i), 32'(rsp_3), 32'd0);
        end
        step(1);

        applyStimulus(3, 1'b0, 32'h20, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
        step(3);
        idle();
        step(6);

        checkOutput("d1_scoreboard_drained", 32'(q1.size()), 32'd0);
        checkOutput("d2_scoreboard_drained", 32'(q2.size()), 32'd0);
        checkOutput("d3_scoreboard_drained", 32'(q3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcb_lib_memory.md
# tcb_lib_memory

Synthesizable TCB subordinate: a byte-enabled RAM that answers TCB requests with a fixed response delay, an optional per-request backpressure count, and an error response for out-of-range addresses. It is the responder counterpart of the VIP manager. It is used as the default memory target in TCB testbenches and as on-chip scratch RAM behind TCB interconnect. Full throughput, one transfer per cycle, is sustained when `WAIT=0`.

## Interface
- `ABW`, 32: address bus width.
- `DBW`, 32: data bus width; must be a multiple of `SLW`.
- `SLW`, 8: byte (select) width; `BEW = DBW/SLW` byte enables.
- `DLY`, 1: response delay in cycles, legal range 1..4.
- `SIZ`, 1024: memory size in bytes; a power of 2 and a multiple of `BEW`.
- `WAIT`, 0: number of backpressure cycles inserted before each transfer, legal range 0..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `tcb_vld`  in  1  request valid.
- `tcb_rdy`  out  BEW? no, 1  request ready.
- `tcb_wen`  in  1  write enable (1 = write, 0 = read).
- `tcb_adr`  in  ABW  byte address.
- `tcb_ben`  in  BEW  byte enables.
- `tcb_wdt`  in  DBW  write data.
- `tcb_rdt`  out  DBW  read data.
- `tcb_err`  out  1  error response.
- `tcb_rsp`  out  1  response valid strobe (`trn` delayed by `DLY`); for debug and benches.

## Operation
- Transfer: `trn = tcb_vld & tcb_rdy`. A request is consumed only on a `trn` edge.
- Wait counter `cnt`, 4 bits:
  - `tcb_rdy = (cnt == WAIT)`, combinational from the `cnt` register.
  - When `tcb_vld & ~tcb_rdy`, `cnt` increments.
  - When `trn`, `cnt` clears to 0.
  - Otherwise `cnt` holds, including when `tcb_vld` drops mid-wait.
- Addressing:
  - Word index = `tcb_adr[log2(SIZ)-1 : log2(BEW)]`; the low `log2(BEW)` bits are ignored.
  - Byte lanes are selected only by `tcb_ben`.
- Range check: `oor = (tcb_adr >= SIZ)`, compared over the full `ABW` width.
- Write (`trn & tcb_wen & ~oor`): lane `b` of the word is written with `tcb_wdt` lane `b` when `tcb_ben[b]`. Other lanes are unchanged.
- Read data: every transfer captures the addressed word *before* any same-edge write (read-before-write), for reads and writes alike.
- Out of range (`trn & oor`):
  - No memory write.
  - Captured data is 0.
  - `err = 1`.
- Response pipeline: `DLY` stages of {valid, rdt, err}.
  - Stage 1 is loaded on every edge: valid = `trn`; data/err as above when `trn`, otherwise 0.
  - Each later stage copies the previous one.
  - Outputs are driven from stage `DLY`. When that stage is invalid, `tcb_rdt = 0` and `tcb_err = 0`.
- `inc`/`rpt`/`lck`/`siz` sideband signals are not supported; the block ignores them if connected upstream.

## Timing
- Reset values:
  - `cnt = 0`, so `tcb_rdy = (WAIT == 0)` while in reset.
  - All pipeline stages are 0, so `tcb_rsp = 0`, `tcb_rdt = 0`, `tcb_err = 0`.
- Memory contents are not reset.
- Latency: a transfer sampled at edge k gives a response valid on the outputs between edge k+DLY-1 and edge k+DLY. The manager samples it at edge k+DLY. With `DLY=1` the response is present in the cycle right after the transfer.
- Back-to-back transfers on consecutive edges give responses on consecutive cycles, in order, with no gaps.
- `WAIT=N>0`: with `tcb_vld` held high, `tcb_rdy` is low for N cycles, then high. The transfer occurs on edge N+1 counted from the first valid edge. The next request again sees N wait cycles.
- A read immediately after a write to the same word returns the new data. There is no bypass hazard, because the write commits at the transfer edge of the first request.
- Reset asserted mid-operation:
  - Pending responses are discarded.
  - `cnt` clears.
  - The request in flight is not performed if reset is asserted at or before its transfer edge.
  - Memory retains previously written data.

## Test plan
- Reset with `WAIT=0`: hold `rst=1` for 3 cycles -> `tcb_rdy=1`, `tcb_rsp=0`, `tcb_rdt=0`, `tcb_err=0`.
- Write then read, `DLY=1`:
  - Write `adr=0x10`, `ben=0xF`, `wdt=0x11223344`; read `adr=0x10` on the next cycle.
  - -> Read response at edge k+1 is `rdt=0x11223344`, `err=0`.
- Partial write:
  - Write `adr=0x10`, `ben=0x2`, `wdt=0x0000AA00`, then read `adr=0x12`.
  - -> `rdt=0x1122AA44`; the low address bits are ignored.
- `DLY=2` throughput:
  - 4 consecutive reads of words 0..3, preloaded with 0xA0..0xA3.
  - -> `tcb_rsp` is high for exactly 4 consecutive cycles starting 2 edges after the first transfer, with `rdt` values 0xA0..0xA3 in order.
- `WAIT=2` backpressure:
  - `tcb_vld` high at edge 0 -> `tcb_rdy` low at edges 0 and 1, high at edge 2; the transfer occurs at edge 2.
  - Dropping `vld` after edge 0 for 1 cycle -> `cnt` holds; the transfer is delayed by 1 cycle.
- Error and reset:
  - Write `adr=0x400` (`SIZ=1024`) -> `err=1`, `rdt=0`, word 0 unchanged.
  - Assert `rst` one cycle after a read transfer with `DLY=3` -> no `tcb_rsp` pulse; a subsequent read of an earlier-written word returns the retained data.
